// File: rtl/pc_sequencer.sv
// Program-flow sequencer: PC register, start/done handshake, relative branches and
// data-memory wait states. Define PC_SEQ_RAS_EN to build the return-address stack.
module pc_sequencer #(
  parameter int PC_BITS   = 9,
  parameter int TGT_BITS  = 8,
  parameter int MEM_WAIT  = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [PC_BITS-1:0]  start_address,
  input  logic                next_ins,
  input  logic                jump_flag,
  input  logic                call,
  input  logic                ret,
  input  logic                mem_op,
  input  logic                halt,
  input  logic [TGT_BITS-1:0] target,
  output logic [PC_BITS-1:0]  pc,
  output logic                busy,
  output logic                stall,
  output logic                done,
  output logic                ras_err
);

  localparam int            CW        = 4;
  localparam bit            WAIT_EN   = (MEM_WAIT > 0);
  localparam logic [CW-1:0] WAIT_LOAD = WAIT_EN ? CW'(MEM_WAIT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_SEQ, K_JMP, K_CALL, K_RET} kind_t;

  typedef struct packed {
    kind_t               kind;
    logic [TGT_BITS-1:0] tgt;
  } upd_t;

  state_t               state, state_d;
  kind_t                in_kind;
  upd_t                 cur, lat;
  logic [CW-1:0]        cnt;
  logic                 do_start, do_apply, do_wait, cnt_dec;
  logic signed [TGT_BITS-1:0] tgt_s;
  logic [PC_BITS-1:0]   pc_off, pc_inc, pc_br, pc_apply, ras_top;
  logic                 ras_push, ras_pop, ras_set_err, ras_full, ras_empty;

  // Retire decode, priority ret > call > jump > sequential (halt handled by the FSM)
  always_comb begin
    in_kind = K_SEQ;
    if (ret)            in_kind = K_RET;
    else if (call)      in_kind = K_CALL;
    else if (jump_flag) in_kind = K_JMP;
`ifndef PC_SEQ_RAS_EN
    if (in_kind == K_RET)       in_kind = K_SEQ;
    else if (in_kind == K_CALL) in_kind = K_JMP;
`endif
  end

  // In WAIT the decision latched at the memory retire is the one applied
  always_comb begin
    cur.kind = in_kind;
    cur.tgt  = target;
    if (state == S_WAIT) cur = lat;
  end

  assign tgt_s  = cur.tgt;
  assign pc_off = PC_BITS'(tgt_s);
  assign pc_inc = pc + PC_BITS'(1);
  assign pc_br  = pc + pc_off;

  always_comb begin
    pc_apply    = pc_inc;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_set_err = 1'b0;
    case (cur.kind)
      K_JMP:  pc_apply = pc_br;
      K_CALL: begin
        pc_apply = pc_br;
        if (ras_full) ras_set_err = 1'b1;
        else          ras_push    = 1'b1;
      end
      K_RET: begin
        if (ras_empty) ras_set_err = 1'b1;
        else begin
          ras_pop  = 1'b1;
          pc_apply = ras_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d  = state;
    do_start = 1'b0;
    do_apply = 1'b0;
    do_wait  = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          do_start = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (next_ins) begin
          if (halt) state_d = S_DONE;
          else if (mem_op && WAIT_EN) begin
            do_wait = 1'b1;
            state_d = S_WAIT;
          end else do_apply = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          do_apply = 1'b1;
          state_d  = S_RUN;
        end else cnt_dec = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc  <= '0;
      cnt <= '0;
      lat <= '0;
    end else begin
      if (do_start)      pc <= start_address;
      else if (do_apply) pc <= pc_apply;
      if (do_wait) begin
        lat <= cur;
        cnt <= WAIT_LOAD;
      end else if (cnt_dec) cnt <= cnt - CW'(1);
    end
  end

  assign busy  = (state == S_RUN) || (state == S_WAIT);
  assign stall = (state == S_WAIT);
  assign done  = (state == S_DONE);

`ifdef PC_SEQ_RAS_EN
  localparam int AW  = $clog2(RAS_DEPTH);
  localparam int SPW = AW + 1;

  logic [RAS_DEPTH-1:0][PC_BITS-1:0] ras_mem;
  logic [SPW-1:0]                    sp;
  logic [AW-1:0]                     wr_idx, top_idx;

  assign wr_idx    = sp[AW-1:0];
  assign top_idx   = AW'(sp - SPW'(1));
  assign ras_full  = (sp == SPW'(RAS_DEPTH));
  assign ras_empty = (sp == '0);
  assign ras_top   = ras_mem[top_idx];

  always_ff @(posedge clock) begin
    if (do_apply && ras_push) ras_mem[wr_idx] <= pc_inc;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || do_start) begin
      sp      <= '0;
      ras_err <= 1'b0;
    end else if (do_apply) begin
      if (ras_push)     sp <= sp + SPW'(1);
      else if (ras_pop) sp <= sp - SPW'(1);
      if (ras_set_err) ras_err <= 1'b1;
    end
  end
`else
  logic ras_unused;
  assign ras_full   = 1'b0;
  assign ras_empty  = 1'b0;
  assign ras_top    = '0;
  assign ras_err    = 1'b0;
  assign ras_unused = ^{ras_push, ras_pop, ras_set_err};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model checked every cycle,
// plus literal expectations from the block's test plan.
module tb_pc_sequencer;
  localparam int PC_BITS = 9, TGT_BITS = 8, MEM_WAIT = 2, RAS_DEPTH = 4;
  localparam int PC_MOD  = 1 << PC_BITS;

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [PC_BITS-1:0]  start_address = '0;
  logic next_ins = 1'b0, jump_flag = 1'b0, call = 1'b0, ret = 1'b0, mem_op = 1'b0, halt = 1'b0;
  logic [TGT_BITS-1:0] target = '0;
  logic [PC_BITS-1:0]  pc;
  logic busy, stall, done, ras_err;

  pc_sequencer #(.PC_BITS(PC_BITS), .TGT_BITS(TGT_BITS), .MEM_WAIT(MEM_WAIT), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
    .next_ins(next_ins), .jump_flag(jump_flag), .call(call), .ret(ret), .mem_op(mem_op),
    .halt(halt), .target(target), .pc(pc), .busy(busy), .stall(stall), .done(done),
    .ras_err(ras_err));

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 memory wait, 3 done
  int m_mode, m_pc, m_wleft, m_pk, m_err;
  logic [7:0] m_pt;
  int m_stack[$];

  function automatic int wrap(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  // 0 sequential, 1 branch, 2 call, 3 return
  function automatic int decode(input logic r, input logic c, input logic j);
`ifdef PC_SEQ_RAS_EN
    if (r) return 3;
    if (c) return 2;
`else
    if (r) return 0;
    if (c) return 1;
`endif
    if (j) return 1;
    return 0;
  endfunction

  task automatic m_apply(input int k, input logic [7:0] t);
    int off = (t >= 8'd128) ? int'(t) - 256 : int'(t);
    case (k)
      1: m_pc = wrap(m_pc + off);
      2: begin
        if (m_stack.size() == RAS_DEPTH) m_err = 1;
        else m_stack.push_back(wrap(m_pc + 1));
        m_pc = wrap(m_pc + off);
      end
      3: begin
        if (m_stack.size() == 0) begin
          m_err = 1;
          m_pc  = wrap(m_pc + 1);
        end else m_pc = m_stack.pop_back();
      end
      default: m_pc = wrap(m_pc + 1);
    endcase
  endtask

  always @(posedge clock) begin
    if (!reset_n) begin
      m_mode = 0; m_pc = 0; m_err = 0; m_wleft = 0; m_stack.delete();
    end else if (m_mode == 0 || m_mode == 3) begin
      if (start) begin
        m_mode = 1; m_pc = int'(start_address); m_err = 0; m_stack.delete();
      end
    end else if (m_mode == 1) begin
      if (next_ins) begin
        if (halt) m_mode = 3;
        else if (mem_op) begin
          m_mode = 2; m_wleft = MEM_WAIT; m_pk = decode(ret, call, jump_flag); m_pt = target;
        end else m_apply(decode(ret, call, jump_flag), target);
      end
    end else begin
      m_wleft--;
      if (m_wleft == 0) begin
        m_apply(m_pk, m_pt);
        m_mode = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("busy", busy, (m_mode == 1 || m_mode == 2));
      check("stall", stall, (m_mode == 2));
      check("done", done, (m_mode == 3));
`ifdef PC_SEQ_RAS_EN
      check("ras_err", ras_err, m_err);
`else
      check("ras_err", ras_err, 0);
`endif
    end
  end

  task automatic clr();
    next_ins = 0; jump_flag = 0; call = 0; ret = 0; mem_op = 0; halt = 0; start = 0; target = '0;
  endtask

  task automatic retire(input logic j, input logic c, input logic r, input logic [7:0] t);
    next_ins = 1; jump_flag = j; call = c; ret = r; target = t;
    @(negedge clock);
    clr();
  endtask

  initial begin
    @(negedge clock);
    chk_en = 1'b1;
    check("rst_pc", pc, 0); check("rst_busy", busy, 0); check("rst_stall", stall, 0);
    check("rst_done", done, 0); check("rst_err", ras_err, 0);
    reset_n = 1;

    start_address = 9'h020; start = 1; @(negedge clock); clr();
    check("start_pc", pc, 9'h020); check("start_busy", busy, 1);
    next_ins = 1; repeat (3) @(negedge clock); clr();
    check("seq3_pc", pc, 9'h023);
    @(negedge clock);
    start = 1; start_address = 9'h1FE; @(negedge clock); clr();
    check("start_ignored_pc", pc, 9'h023);

    next_ins = 1; halt = 1; @(negedge clock); halt = 0;
    check("halt_done", done, 1); check("halt_pc", pc, 9'h023);
    @(negedge clock); clr();
    check("halt_frozen_pc", pc, 9'h023);
    start = 1; @(negedge clock); clr();
    check("restart_pc", pc, 9'h1FE); check("restart_done", done, 0);

    retire(1, 0, 0, 8'h05); check("wrap_fwd_pc", pc, 9'h003);
    retire(1, 0, 0, 8'hFB); check("wrap_back_pc", pc, 9'h1FE);
    next_ins = 1; repeat (2) @(negedge clock); clr();
    check("inc_wrap_pc", pc, 9'h000);
    retire(1, 0, 0, 8'h10); check("to_010", pc, 9'h010);

    next_ins = 1; mem_op = 1; @(negedge clock);
    check("wait1_stall", stall, 1); check("wait1_pc", pc, 9'h010);
    jump_flag = 1; target = 8'h40; @(negedge clock);
    check("wait2_stall", stall, 1);
    next_ins = 0; @(negedge clock); clr();
    check("wait_end_stall", stall, 0); check("wait_end_pc", pc, 9'h011);
    next_ins = 1; mem_op = 1; jump_flag = 1; target = 8'h08; @(negedge clock); clr();
    repeat (2) @(negedge clock);
    check("memjmp_pc", pc, 9'h019);

    retire(1, 0, 0, 8'h27); check("to_040", pc, 9'h040);
    retire(0, 1, 0, 8'h10); check("call_pc", pc, 9'h050);
    retire(0, 0, 1, 8'h00);
`ifdef PC_SEQ_RAS_EN
    check("ret_pc", pc, 9'h041);
`else
    check("ret_pc", pc, 9'h051);
`endif
    for (int i = 0; i < 4; i++) retire(0, 1, 0, 8'h01);
    check("four_calls_err", ras_err, 0);
    retire(0, 1, 0, 8'h01);
    for (int i = 0; i < 5; i++) retire(0, 0, 1, 8'h00);
`ifdef PC_SEQ_RAS_EN
    check("overflow_err", ras_err, 1); check("underflow_pc", pc, 9'h043);
`else
    check("overflow_err", ras_err, 0); check("underflow_pc", pc, 9'h05B);
`endif

    next_ins = 1; halt = 1; mem_op = 1; @(negedge clock); clr();
    check("halt_mem_done", done, 1); check("halt_mem_stall", stall, 0);
    start = 1; start_address = 9'h000; @(negedge clock); clr();
    check("restart0_pc", pc, 0); check("restart0_done", done, 0); check("restart0_err", ras_err, 0);

    retire(1, 0, 0, 8'h10);
    next_ins = 1; mem_op = 1; @(negedge clock); clr();
    check("midwait_stall", stall, 1);
    reset_n = 0; @(negedge clock);
    check("midrst_pc", pc, 0); check("midrst_busy", busy, 0);
    check("midrst_stall", stall, 0); check("midrst_done", done, 0);
    reset_n = 1; @(negedge clock);
    start = 1; start_address = 9'h100; @(negedge clock); clr();
    check("final_start_pc", pc, 9'h100);
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
